// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline stage registers: state encoding and default bubble payload.
// Combinational constants only; no latency and no backpressure of their own.
package pipe_skid_reg_pkg;

  // State value doubles as the occupancy count (entries held).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Replicated to payload width to form the default NOP bubble.
  localparam logic NOP_BIT = 1'b0;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for a pipeline stage: upstream side (in_*) and downstream side (out_*).
// Wires only; latency and backpressure belong to whichever stage is bound to the slave modport.
interface pipe_skid_reg_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  // Environment side: feeds the stage and consumes its output.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_data_reg.sv
// W-bit payload register with load enable and synchronous clear to NOP; clear wins over load.
// One-cycle latency; no handshake, the owner decides when to load.
module pipe_data_reg #(
  parameter int           W   = 32,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= NOP;
    end else if (clr) begin
      q <= NOP;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with one-entry skid buffer and flush; payload appears one cycle after acceptance.
// in_ready is a flop (low only when both entries are held), so no combinational ready path crosses the stage.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int           W   = 32,
  parameter logic [W-1:0] NOP = {W{NOP_BIT}}
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  pipe_skid_reg_if.slave       bus,
  output logic [1:0]           occupancy
);

  state_t       state_q;
  state_t       state_d;
  logic         rdy_q;
  logic         rdy_d;

  logic         up_xfer;
  logic         dn_xfer;

  logic         main_en;
  logic         main_clr;
  logic [W-1:0] main_d;
  logic [W-1:0] main_q;

  logic         skid_en;
  logic         skid_clr;
  logic [W-1:0] skid_q;

  assign up_xfer = bus.in_valid & rdy_q;
  assign dn_xfer = (state_q != ST_EMPTY) & bus.out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    main_en  = 1'b0;
    main_clr = 1'b0;
    main_d   = bus.in_data;
    skid_en  = 1'b0;
    skid_clr = 1'b0;

    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (up_xfer && !dn_xfer) begin
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (up_xfer && dn_xfer) begin
            main_en = 1'b1;
          end else if (dn_xfer) begin
            // Going empty: clear main so downstream muxes see a bubble.
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the downstream side can move.
          if (dn_xfer) begin
            state_d  = ST_ONE;
            main_en  = 1'b1;
            main_d   = skid_q;
            skid_clr = 1'b1;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end

    rdy_d = (state_d != ST_FULL);
  end

  pipe_data_reg #(
    .W   (W),
    .NOP (NOP)
  ) u_main (
    .clk  (clk),
    .rstn (rstn),
    .en   (main_en),
    .clr  (main_clr),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_data_reg #(
    .W   (W),
    .NOP (NOP)
  ) u_skid (
    .clk  (clk),
    .rstn (rstn),
    .en   (skid_en),
    .clr  (skid_clr),
    .d    (bus.in_data),
    .q    (skid_q)
  );

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = main_q;
  assign occupancy     = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus a random handshake run against a queue scoreboard.
module tb_pipe_skid_reg;

  localparam int           W   = 8;
  localparam logic [W-1:0] NOP = 8'hE7;

  logic       clk  = 1'b0;
  logic       rstn = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] occupancy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb[$];

  pipe_skid_reg_if #(.W(W)) bus ();

  pipe_skid_reg #(
    .W   (W),
    .NOP (NOP)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs settle 1 time unit after each rising edge, so the
  // falling edge sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
    end else begin
      checks++;
      if (int'(occupancy) != sb.size()) begin
        errors++;
        $display("FAIL sb_occupancy t=%0t: got %0d expected %0d", $time, occupancy, sb.size());
      end
      checks++;
      if (bus.out_valid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL sb_out_valid t=%0t: got %b expected %b", $time, bus.out_valid, sb.size() != 0);
      end
      checks++;
      if (bus.in_ready !== (sb.size() < 2)) begin
        errors++;
        $display("FAIL sb_in_ready t=%0t: got %b expected %b", $time, bus.in_ready, sb.size() < 2);
      end
      if (!bus.out_valid) begin
        checks++;
        if (bus.out_data !== NOP) begin
          errors++;
          $display("FAIL sb_bubble_data t=%0t: got %h expected %h", $time, bus.out_data, NOP);
        end
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
          checks++;
          if (bus.out_data !== sb[0]) begin
            errors++;
            $display("FAIL sb_order t=%0t: got %h expected %h", $time, bus.out_data, sb[0]);
          end
          void'(sb.pop_front());
        end
        if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || occupancy !== 2'd0 || bus.out_data !== NOP) begin
      errors++;
      $display("FAIL reset_values: got v=%b r=%b occ=%0d d=%h expected v=0 r=1 occ=0 d=%h",
               bus.out_valid, bus.in_ready, occupancy, bus.out_data, NOP);
    end
    repeat (2) cyc();
    rstn = 1'b1;
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: got v=%b occ=%0d expected v=0 occ=0", bus.out_valid, occupancy);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] pat[3];
    pat = '{8'h11, 8'h22, 8'h33};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pat[i];
      cyc();
      checks++;
      if (bus.out_data !== pat[i] || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_data[%0d]: got %h v=%b expected %h v=1", i, bus.out_data, bus.out_valid, pat[i]);
      end
      checks++;
      if (bus.in_ready !== 1'b1 || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_flow[%0d]: got r=%b occ=%0d expected r=1 occ=1", i, bus.in_ready, occupancy);
      end
    end
    bus.in_valid = 1'b0;
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: got v=%b occ=%0d expected v=0 occ=0", bus.out_valid, occupancy);
    end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA1;
    cyc();
    bus.in_data = 8'hA2;
    cyc();
    checks++;
    if (occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 8'hA1) begin
      errors++;
      $display("FAIL stall_full: got occ=%0d r=%b d=%h expected occ=2 r=0 d=a1", occupancy, bus.in_ready, bus.out_data);
    end
    bus.in_data = 8'hA3;
    cyc();
    checks++;
    if (occupancy !== 2'd2 || bus.out_data !== 8'hA1) begin
      errors++;
      $display("FAIL stall_hold: got occ=%0d d=%h expected occ=2 d=a1", occupancy, bus.out_data);
    end
    bus.out_ready = 1'b1;
    cyc();
    checks++;
    if (bus.out_data !== 8'hA2 || occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_skid_move: got d=%h occ=%0d r=%b expected d=a2 occ=1 r=1", bus.out_data, occupancy, bus.in_ready);
    end
    cyc();
    checks++;
    if (bus.out_data !== 8'hA3 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL stall_third: got d=%h occ=%0d expected d=a3 occ=1", bus.out_data, occupancy);
    end
    bus.in_valid = 1'b0;
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got v=%b expected v=0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hB1;
    cyc();
    bus.in_data = 8'hB2;
    cyc();
    flush       = 1'b1;
    bus.in_data = 8'hB3;
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== NOP || occupancy !== 2'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: got v=%b d=%h occ=%0d r=%b expected v=0 d=%h occ=0 r=1",
               bus.out_valid, bus.out_data, occupancy, bus.in_ready, NOP);
    end
    flush       = 1'b0;
    bus.in_data = 8'hB4;
    cyc();
    flush         = 1'b1;
    bus.in_data   = 8'hB5;
    bus.out_ready = 1'b1;
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0 || occupancy !== 2'd0 || bus.out_data !== NOP) begin
      errors++;
      $display("FAIL flush_one: got v=%b occ=%0d d=%h expected v=0 occ=0 d=%h", bus.out_valid, occupancy, bus.out_data, NOP);
    end
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_discard: got v=%b d=%h expected v=0", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_simultaneous();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hC1;
    cyc();
    bus.in_data   = 8'hC2;
    bus.out_ready = 1'b1;
    cyc();
    checks++;
    if (bus.out_data !== 8'hC2 || occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_replace: got d=%h occ=%0d r=%b expected d=c2 occ=1 r=1", bus.out_data, occupancy, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL simul_drain: got v=%b occ=%0d expected v=0 occ=0", bus.out_valid, occupancy);
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hD1;
    cyc();
    bus.in_data = 8'hD2;
    cyc();
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL midreset_fill: got occ=%0d expected occ=2", occupancy);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== NOP || bus.in_ready !== 1'b1 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL midreset_async: got v=%b d=%h r=%b occ=%0d expected v=0 d=%h r=1 occ=0",
               bus.out_valid, bus.out_data, bus.in_ready, occupancy, NOP);
    end
    bus.in_valid = 1'b0;
    cyc();
    rstn = 1'b1;
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0 || occupancy !== 2'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_after: got v=%b occ=%0d r=%b expected v=0 occ=0 r=1", bus.out_valid, occupancy, bus.in_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = (i % 2000 < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus.in_data   = W'($urandom);
      flush         = ($urandom_range(0, 63) == 0);
      cyc();
    end
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    checks++;
    if (sb.size() != 0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL random_drain: got pending=%0d occ=%0d expected pending=0 occ=0", sb.size(), occupancy);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_simultaneous();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
